// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: BCD time-of-day engine with 12/24h display and accelerating auto-repeat adjust.
// Define BCD_TK_ALARM_EN to add the HH:MM alarm ports and logic.
module bcd_timekeeper #(
  parameter int CORE_CLOCK = 25_000_000,
  parameter int CNT_W      = $clog2(CORE_CLOCK),
  parameter int REP_DELAY  = 16,
  parameter int REP_DEC    = 1,
  parameter int REP_MIN    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic        mode_12h,
  input  logic        adj_hrs,
  input  logic        adj_min,
  input  logic        adj_sec,
`ifdef BCD_TK_ALARM_EN
  input  logic [15:0] alarm_hhmm,
  input  logic        alarm_on,
  output logic        alarm,
`endif
  output logic [23:0] bcd_time,
  output logic        pm,
  output logic        sec_pulse,
  output logic        min_roll,
  output logic [3:0]  color_offset
);
  localparam int RW = $clog2(REP_DELAY + 1);
  typedef enum logic {IDLE, WAIT} rep_t;
  logic [2:0] btn, pulse;
  logic rst_q, ft, hold, tick, tick_q, min_q, sec_wrap, min_wrap;
  logic [7:0] hrs, mins, secs, h12, disp_h;
  logic [CNT_W-1:0] pre;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return v == top ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  assign btn = {adj_hrs, adj_min, adj_sec};
  // frames seen during or right after reset are ignored so no pulse escapes
  assign ft = frame_tick & ~rst_q & ~reset;
  assign hold = pause | (|btn);
  assign tick = ~hold && pre == CNT_W'(CORE_CLOCK - 1);
  assign sec_wrap = tick && secs == 8'h59;
  assign min_wrap = sec_wrap && mins == 8'h59;
  for (genvar i = 0; i < 3; i++) begin : g_rep
    rep_t st, st_n;
    logic [RW-1:0] cnt, cnt_n, intv, intv_n, dec;
    logic p;
    always_comb begin
      dec = int'(intv) >= REP_MIN + REP_DEC ? intv - RW'(REP_DEC) : RW'(REP_MIN);
      st_n = st;
      cnt_n = cnt;
      intv_n = intv;
      p = 1'b0;
      if (ft && !btn[i]) begin
        st_n = IDLE;
        intv_n = RW'(REP_DELAY);
      end else if (ft && st == IDLE) begin
        st_n = WAIT;
        cnt_n = intv;
        p = 1'b1;
      end else if (ft && cnt == RW'(1)) begin
        cnt_n = dec;
        intv_n = dec;
        p = 1'b1;
      end else if (ft) cnt_n = cnt - RW'(1);
    end
    always_ff @(posedge clk)
      if (reset) begin
        st <= IDLE;
        cnt <= '0;
        intv <= RW'(REP_DELAY);
      end else begin
        st <= st_n;
        cnt <= cnt_n;
        intv <= intv_n;
      end
    assign pulse[i] = p;
  end
  // pulses only occur with a button high, which holds the prescaler, so they never collide with a natural tick
  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      pre <= '0;
      hrs <= '0;
      mins <= '0;
      secs <= '0;
      tick_q <= 1'b0;
      min_q <= 1'b0;
    end else begin
      pre <= hold || tick ? '0 : pre + CNT_W'(1);
      secs <= tick || pulse[0] ? bcd_inc(secs, 8'h59) : secs;
      mins <= sec_wrap || pulse[1] ? bcd_inc(mins, 8'h59) : mins;
      hrs <= min_wrap || pulse[2] ? bcd_inc(hrs, 8'h23) : hrs;
      tick_q <= tick;
      min_q <= sec_wrap | pulse[1];
    end
  end
  assign h12 = hrs == 8'h00 ? 8'h12 : hrs <= 8'h12 ? hrs :
               hrs[3:0] >= 4'd2 ? {hrs[7:4] - 4'd1, hrs[3:0] - 4'd2} : {hrs[7:4] - 4'd2, hrs[3:0] + 4'd8};
  assign disp_h = mode_12h ? h12 : hrs;
  always_ff @(posedge clk)
    if (reset) begin
      bcd_time <= {mode_12h ? 8'h12 : 8'h00, 16'h0000};
      pm <= 1'b0;
      sec_pulse <= 1'b0;
      min_roll <= 1'b0;
      color_offset <= 4'd0;
    end else begin
      bcd_time <= {disp_h, mins, secs};
      pm <= hrs >= 8'h12;
      sec_pulse <= tick_q;
      min_roll <= min_q;
      color_offset <= color_offset + {3'b000, min_q};
    end
`ifdef BCD_TK_ALARM_EN
  logic upd_q;
  logic [2:0] btn_q;
  logic [5:0] al_cnt;
  // a match reached on this update wins over a press clear so adjusting onto the alarm time arms it
  always_ff @(posedge clk)
    if (reset) begin
      upd_q <= 1'b0;
      btn_q <= '0;
      al_cnt <= '0;
      alarm <= 1'b0;
    end else begin
      upd_q <= tick | (|pulse);
      btn_q <= btn;
      if (!alarm_on) alarm <= 1'b0;
      else if (upd_q && {hrs, mins} == alarm_hhmm && secs == 8'h00) begin
        alarm <= 1'b1;
        al_cnt <= '0;
      end else if (|(btn & ~btn_q) || (tick_q && alarm && al_cnt == 6'd59)) alarm <= 1'b0;
      else if (tick_q && alarm) al_cnt <= al_cnt + 6'd1;
    end
`endif
endmodule

// File: doc/bcd_timekeeper.md
# bcd_timekeeper

Parametrised time-of-day engine for the VGA clock display path. It keeps hours, minutes and seconds in BCD from a configurable core-clock prescaler, with runtime 12/24-hour display and frame-paced auto-repeat adjust buttons whose repeat rate accelerates. Adjusting one field never carries into another. The digit renderer and font ROM consume its registered outputs, so time-keeping is decoupled from pixel generation.

## Interface
- `CORE_CLOCK`, 25_000_000: `clk` cycles per second; must be ≥2.
- `CNT_W`, `$clog2(CORE_CLOCK)`: prescaler width.
- `REP_DELAY`, 16: frame ticks from the first pulse to the first repeat.
- `REP_DEC`, 1: interval decrement applied after each repeat pulse.
- `REP_MIN`, 2: floor of the repeat interval; must be ≥1 and ≤ `REP_DELAY`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle strobe per video frame; buttons are sampled only on this strobe.
- `pause` in 1: holds the prescaler while high.
- `mode_12h` in 1: 1 selects 12-hour display.
- `adj_hrs`, `adj_min`, `adj_sec` in 1 each: level buttons, already synchronised.
- `bcd_time` out 24: `{hrs_d, hrs_u, min_d, min_u, sec_d, sec_u}`, 4 bits each.
- `pm` out 1: PM flag, valid in both modes.
- `sec_pulse` out 1: one-cycle strobe on each natural seconds increment.
- `min_roll` out 1: one-cycle strobe whenever minutes change, naturally or by adjust.
- `color_offset` out 4: incremented on every `min_roll`, wraps mod 16.
- `alarm` out 1: present only with `BCD_TK_ALARM_EN`.
- `alarm_hhmm` in 16: present only with `BCD_TK_ALARM_EN`.
- `alarm_on` in 1: present only with `BCD_TK_ALARM_EN`.

## Operation
- **Internal state:** hours are held as 24-hour BCD 00–23, minutes and seconds as 00–59.
- **Reset:** all fields 0, prescaler 0, `color_offset` 0. All strobes and `alarm` are low. All repeat FSMs go to IDLE with interval `REP_DELAY`.
- **Reset display:** the first output after reset is `bcd_time`=0 in 24-hour mode, or hours=12 with `pm`=0 in 12-hour mode.
- **Prescaler:** counts 0..`CORE_CLOCK`-1 and wraps. At the terminal count, seconds increment with a full carry chain: 59 s → 00 with minutes +1, 59 min → 00 with hours +1, 23 h → 00.
- **Prescaler hold:** the prescaler is held at 0 while `pause` is high or any adjust button is high. No natural tick occurs in that time.
- **Repeat FSM (one per button):** states are IDLE, WAIT.
  - IDLE: on `frame_tick` with the button high, emit an adjust pulse, load the counter with `interval`, go to WAIT.
  - WAIT: each `frame_tick` with the button high decrements the counter. When it reaches 0, emit a pulse, set `interval` = max(`interval`-`REP_DEC`, `REP_MIN`), and reload the counter.
  - Any `frame_tick` with the button low: go to IDLE and restore `interval`=`REP_DELAY`.
- **Adjust pulse:** increments only its own field with wrap and no carry: sec 59→00, min 59→00, hrs 23→00.
- **Simultaneous pulses:** the three buttons are independent; pulses in the same cycle all apply.
- **12-hour display:** hour 0 shows 12 with `pm`=0; 1–11 show as-is with `pm`=0; 12 shows 12 with `pm`=1; 13–23 show h-12 with `pm`=1. In 24-hour mode `pm` = (h ≥ 12).
- **Mode change:** toggling `mode_12h` changes only the display, never the stored time.

## Timing
- State update happens on the edge that sees the terminal count or the adjust pulse.
- `bcd_time`, `pm`, `min_roll`, `color_offset` and `alarm` are registered: 1 cycle of latency after the state update.
- `sec_pulse` is asserted in the same output cycle as the new seconds value.
- An adjust pulse occurs in the cycle of `frame_tick`. Its result is visible on `bcd_time` 2 cycles after that `frame_tick`.
- Reset mid-repeat or mid-second aborts immediately. No pulse is emitted in the reset cycle or the cycle after it.

## Configuration
- `BCD_TK_ALARM_EN` defined:
  - Adds `alarm_hhmm`, `alarm_on`, `alarm`.
  - `alarm` sets when `alarm_on`=1 and the internal 24-hour HH:MM equals `alarm_hhmm` at seconds 00, whether reached naturally or by adjust.
  - `alarm` clears when `alarm_on`=0, when any adjust button is pressed, or after 60 natural seconds.
- `BCD_TK_ALARM_EN` undefined: the three alarm ports and all alarm logic are absent.

## Test plan
- **Basic count:** `CORE_CLOCK`=10, reset, run 10 cycles → `sec_u`=1, exactly one `sec_pulse`, `min_roll` never asserted.
- **Full carry:** set 23:59:59 via adjust with `CORE_CLOCK`=10, release, run 10 cycles → `bcd_time`=0x000000, one `min_roll`, `color_offset` incremented by 1.
- **12-hour display:** `mode_12h`=1.
  - 00:00 → hrs 0x12, `pm`=0.
  - Advance to 13:00 → hrs 0x01, `pm`=1.
  - 12:00 → hrs 0x12, `pm`=1.
- **Auto-repeat:** hold `adj_min` for 40 `frame_tick`s (frames 0..39) with defaults → pulses at frames 0, 16, 31. Minutes = 03, hours unchanged, no `sec_pulse` during the hold.
- **No-carry wrap:** seconds=59, one `adj_sec` pulse → seconds 00, minutes unchanged.
- **Alarm (with `BCD_TK_ALARM_EN`):** `alarm_hhmm`=0x0001, `alarm_on`=1, `CORE_CLOCK`=10, run from reset → `alarm` rises at 00:01:00. Drop `alarm_on` → `alarm` falls within 2 cycles.
